// File: rtl/gb_pkg.sv
// Shared types and helpers for the GB read scheduler.
package gb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_DRAIN
    } state_t;

    localparam int unsigned GB_ADDR_W = 12;
    localparam int unsigned GB_LEN_W  = 4;
    localparam int unsigned GB_MAX_PE = 64;

    function automatic logic [GB_MAX_PE-1:0] onehot(input int unsigned idx);
        return GB_MAX_PE'(1) << idx;
    endfunction

endpackage

// File: rtl/gb_rd_sched_if.sv
// Global-buffer read port: beat request/address handshake plus returned-data valid.
interface gb_rd_sched_if #(
    parameter int unsigned ADDR_W = gb_pkg::GB_ADDR_W
);
    logic              gb_rd_en;
    logic [ADDR_W-1:0] gb_rd_addr;
    logic              gb_rd_rdy;
    logic              gb_dat_vld;

    modport master (
        output gb_rd_en,
        output gb_rd_addr,
        input  gb_rd_rdy,
        input  gb_dat_vld
    );

    modport slave (
        input  gb_rd_en,
        input  gb_rd_addr,
        output gb_rd_rdy,
        output gb_dat_vld
    );
endinterface

// File: rtl/gb_rd_sched_rr_pick.sv
// Rotating-priority first-one finder: first set req bit scanning ptr, ptr+1, ... mod N.
module rr_pick #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        // N is a power of two, so the IW-bit sum wraps the scan naturally.
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[ptr + IW'(i)]) begin
                idx = ptr + IW'(i);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gb_rd_sched.sv
// Round-robin GB read scheduler: grants one PE a multi-beat burst, drains read latency, pulses done.
// Optional macro GB_SCHED_PERF_EN adds saturating perf_bursts / perf_stall counters.
module gb_rd_sched
    import gb_pkg::*;
#(
    parameter int unsigned PE_BLOCK = 16,
    parameter int unsigned ADDR_W   = GB_ADDR_W,
    parameter int unsigned LEN_W    = GB_LEN_W,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PE_BLOCK-1:0]        req,
    input  logic [PE_BLOCK*ADDR_W-1:0] req_addr,
    input  logic [PE_BLOCK*LEN_W-1:0]  req_len,
    output logic [PE_BLOCK-1:0]    gnt,
    output logic [PE_BLOCK-1:0]    done,
    gb_rd_sched_if.master          gb,
    output logic [PE_BLOCK-1:0]    pe_dat_vld,
    output logic                   busy
`ifdef GB_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_bursts,
    output logic [31:0]            perf_stall
`endif
);
    localparam int unsigned PW = $clog2(PE_BLOCK);
    localparam int unsigned DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       owner;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [LEN_W-1:0]    cnt;
    logic [DW-1:0]       dcnt;
    logic [PE_BLOCK-1:0] owner_oh;

    rr_pick #(
        .N  (PE_BLOCK),
        .IW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_oh   = PE_BLOCK'(onehot(32'(owner)));
    assign pe_dat_vld = gb.gb_dat_vld ? gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            dcnt          <= '0;
            gnt           <= '0;
            done          <= '0;
            busy          <= 1'b0;
            gb.gb_rd_en   <= 1'b0;
            gb.gb_rd_addr <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        owner         <= pick_idx;
                        gb.gb_rd_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                        cnt           <= req_len[pick_idx*LEN_W +: LEN_W];
                        gnt           <= PE_BLOCK'(onehot(32'(pick_idx)));
                        gb.gb_rd_en   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (gb.gb_rd_rdy) begin
                        gb.gb_rd_addr <= gb.gb_rd_addr + ADDR_W'(1);
                        if (cnt == '0) begin
                            gb.gb_rd_en <= 1'b0;
                            dcnt        <= DW'(RD_LAT - 1);
                            state       <= ST_DRAIN;
                            // With a one-cycle latency the first drain cycle is also the last.
                            if (RD_LAT == 1) done <= owner_oh;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == '0) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner + 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        dcnt <= dcnt - 1'b1;
                        if (dcnt == DW'(1)) done <= owner_oh;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef GB_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bursts <= '0;
            perf_stall  <= '0;
        end else begin
            if (done != '0 && perf_bursts != '1)
                perf_bursts <= perf_bursts + 32'd1;
            if (state == ST_BURST && !gb.gb_rd_rdy && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gb_rd_sched.sv
// Bench for gb_rd_sched: transaction-level model compared every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_gb_rd_sched;
    localparam int unsigned N  = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned LW = 4;
    localparam int unsigned RL = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic [N-1:0]    gnt, done, pe_dat_vld;
    logic            busy;
    logic [RL-1:0]   vpipe;
    logic            stray;
    int              checks   = 0;
    int              failures = 0;
    logic [AW-1:0]   acc[$];
`ifdef GB_SCHED_PERF_EN
    logic [31:0]     perf_bursts, perf_stall;
`endif

    gb_rd_sched_if #(.ADDR_W(AW)) gb();

    gb_rd_sched #(
        .PE_BLOCK (N),
        .ADDR_W   (AW),
        .LEN_W    (LW),
        .RD_LAT   (RL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .gnt        (gnt),
        .done       (done),
        .gb         (gb),
        .pe_dat_vld (pe_dat_vld),
        .busy       (busy)
`ifdef GB_SCHED_PERF_EN
        ,
        .perf_bursts (perf_bursts),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // GB SRAM stand-in: data valid RL cycles after each accepted beat.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= RL'({vpipe, gb.gb_rd_en && gb.gb_rd_rdy});
    end
    assign gb.gb_dat_vld = vpipe[RL-1] | stray;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pe(input int unsigned pe, input logic [AW-1:0] a, input logic [LW-1:0] l);
        req_addr[pe*AW +: AW] = a;
        req_len[pe*LW +: LW]  = l;
    endtask

    task automatic wait_gnt(input bit want_nz, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (((gnt != '0) != want_nz) && n < limit) begin
            tick();
            n++;
        end
        if ((gnt != '0) != want_nz) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual_gnt=%0h", tag, gnt);
        end
    endtask

    task automatic wait_idle(input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL %s timeout actual_busy=%0b", tag, busy);
        end
    endtask

    // Runs one granted burst, recording accepted beat addresses into acc.
    task automatic collect(input int unsigned pe, input bit alt, input string tag);
        bit ph  = 1'b0;
        bit got = 1'b0;
        acc.delete();
        for (int c = 0; c < 40 && !got; c++) begin
            tick();
            if (done != '0) begin
                got = 1'b1;
                chk({tag, "_done"}, done, N'(1) << pe);
            end else begin
                gb.gb_rd_rdy = alt ? ph : 1'b1;
                ph = ~ph;
                if (gb.gb_rd_en && gb.gb_rd_rdy) acc.push_back(gb.gb_rd_addr);
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        req = '0;
        gb.gb_rd_rdy = 1'b1;
    endtask

    // Transaction-level model: a granted request becomes a queue of beat addresses
    // followed by RL drain cycles; compared at every falling edge.
    initial begin : model
        bit            m_busy;
        bit            f;
        int unsigned   m_owner, m_ptr, m_drain, len;
        logic [AW-1:0] base;
        logic [AW-1:0] m_q[$];
        logic [N-1:0]  e_gnt, e_done;
        m_busy = 0; m_ptr = 0; m_owner = 0; m_drain = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_ptr = 0; m_drain = 0; m_q.delete();
            end
            e_gnt  = m_busy ? N'(1) << m_owner : '0;
            e_done = (m_busy && m_q.size() == 0 && m_drain == 1) ? e_gnt : '0;
            chk("m_gnt",   gnt, e_gnt);
            chk("m_done",  done, e_done);
            chk("m_busy",  busy, m_busy);
            chk("m_rd_en", gb.gb_rd_en, m_busy && m_q.size() > 0);
            if (m_busy && m_q.size() > 0) chk("m_rd_addr", gb.gb_rd_addr, m_q[0]);
            else if (!rst_n)              chk("m_rd_addr_rst", gb.gb_rd_addr, 0);
            chk("m_pe_vld", pe_dat_vld, gb.gb_dat_vld ? e_gnt : '0);
            if (rst_n) begin
                if (!m_busy) begin
                    if (req != '0) begin
                        f = 0;
                        for (int k = 0; k < N; k++)
                            if (!f && req[(m_ptr + k) % N]) begin
                                f = 1;
                                m_owner = (m_ptr + k) % N;
                            end
                        base = req_addr[m_owner*AW +: AW];
                        len  = req_len[m_owner*LW +: LW];
                        for (int b = 0; b <= len; b++) m_q.push_back(AW'(base + b));
                        m_drain = RL;
                        m_busy  = 1;
                    end
                end else if (m_q.size() > 0) begin
                    if (gb.gb_rd_rdy) void'(m_q.pop_front());
                end else begin
                    m_drain--;
                    if (m_drain == 0) begin
                        m_busy = 0;
                        m_ptr  = (m_owner + 1) % N;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin : stim
        logic [AW-1:0] wrap_exp [4];
        wrap_exp = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        rst_n = 1'b0; req = '0; req_addr = '0; req_len = '0;
        gb.gb_rd_rdy = 1'b1; stray = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", gb.gb_rd_en, 0);
        chk("rst_addr", gb.gb_rd_addr, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Single request, PE3, three beats.
        set_pe(3, 12'h010, 4'd2);
        req = 16'h0008;
        tick(); chk("t1_gnt_c1", gnt, 16'h0008); chk("t1_en_c1", gb.gb_rd_en, 1); chk("t1_addr_c1", gb.gb_rd_addr, 12'h010);
        tick(); chk("t1_addr_c2", gb.gb_rd_addr, 12'h011);
        tick(); chk("t1_addr_c3", gb.gb_rd_addr, 12'h012);
        tick(); chk("t1_done_c4", done, 16'h0008); chk("t1_en_c4", gb.gb_rd_en, 0); chk("t1_pevld_c4", pe_dat_vld, 16'h0008);
        req = '0;
        tick(); chk("t1_busy_c5", busy, 0); chk("t1_gnt_c5", gnt, 0);
        stray = 1'b1;
        tick(); stray = 1'b0;

        // Round robin with every PE requesting single-beat bursts.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_pe(i, AW'(i * 16), 4'd0);
        req = 16'hFFFF;
        for (int k = 0; k <= N; k++) begin
            wait_gnt(1, 10, "t2_wait_gnt");
            chk("t2_order", gnt, N'(1) << (k % N));
            if (k == N) req = '0;
            wait_gnt(0, 10, "t2_wait_release");
        end
        wait_idle(10, "t2_idle");

        // Backpressure on alternate cycles, four beats.
        set_pe(5, 12'h100, 4'd3);
        req = 16'h0020;
        collect(5, 1'b1, "t3");
        chk("t3_nbeats", acc.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acc.size()) chk("t3_addr", acc[i], 12'h100 + i);
        wait_idle(10, "t3_idle");
        tick();

        // Address wrap inside a burst.
        set_pe(9, 12'hFFE, 4'd3);
        req = 16'h0200;
        collect(9, 1'b0, "t4");
        chk("t4_nbeats", acc.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < acc.size()) chk("t4_addr", acc[i], wrap_exp[i]);
        wait_idle(10, "t4_idle");
        tick();

        // Owner drops req mid-burst while PE7 rises.
        set_pe(2, 12'h200, 4'd5);
        set_pe(7, 12'h300, 4'd0);
        req = 16'h0004;
        tick(); tick(); tick();
        req = 16'h0080;
        begin
            int n = 0;
            while (done == '0 && n < 20) begin tick(); n++; end
        end
        chk("t5_done", done, 16'h0004);
        wait_gnt(0, 10, "t5_release");
        wait_gnt(1, 10, "t5_regrant");
        chk("t5_next_gnt", gnt, 16'h0080);
        req = '0;
        wait_idle(10, "t5_idle");
        tick();

        // Reset in the middle of a burst, then ptr must restart at 0.
        set_pe(12, 12'h400, 4'd7);
        req = 16'h1000;
        tick(); tick(); tick();
        rst_n = 1'b0; req = '0;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_en", gb.gb_rd_en, 0);
        chk("t6_rst_addr", gb.gb_rd_addr, 0);
        chk("t6_rst_busy", busy, 0);
        tick();
        set_pe(1, 12'h050, 4'd0);
        set_pe(15, 12'h060, 4'd0);
        rst_n = 1'b1;
        req = 16'h8002;
        wait_gnt(1, 10, "t6_wait_gnt");
        chk("t6_gnt", gnt, 16'h0002);
        wait_gnt(0, 10, "t6_release");
        wait_gnt(1, 10, "t6_wait_gnt2");
        chk("t6_gnt2", gnt, 16'h8000);
        req = '0;
        wait_idle(10, "t6_idle");
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gb_rd_sched.md
Name: gb_rd_sched

Overview:
Round-robin read scheduler that shares the single global-buffer (GB) read port among PE_BLOCK processing-element requesters.
- Arbitrates pending requests with rotating priority.
- Holds the grant for a whole multi-beat burst and generates incrementing GB addresses under a valid/ready handshake.
- Routes returned read-data valids to the owning PE, then signals completion.
- Sits between the PE array request lines and the GB SRAM read port.

Parameters:
PE_BLOCK, 16, number of requesting PEs (power of 2, ≥2)
ADDR_W, 12, GB word-address width
LEN_W, 4, burst length field width; beats = len+1
RD_LAT, 1, GB read latency in cycles from accepted beat to data valid (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
req  in  PE_BLOCK  per-PE read request level, held until matching done
req_addr  in  PE_BLOCK*ADDR_W  per-PE start address, PE i at bits [i*ADDR_W +: ADDR_W]
req_len  in  PE_BLOCK*LEN_W  per-PE burst length-1, same packing
gnt  out  PE_BLOCK  one-hot owner of GB port, held for entire transaction
done  out  PE_BLOCK  one-hot single-cycle completion pulse
gb_rd_en  out  1  read beat valid toward GB
gb_rd_addr  out  ADDR_W  read beat address
gb_rd_rdy  in  1  GB accepts beat when gb_rd_en && gb_rd_rdy
gb_dat_vld  in  1  GB returned-data valid
pe_dat_vld  out  PE_BLOCK  gb_dat_vld steered one-hot to owner (combinational)
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, ptr=0, owner=0, beat cnt=0, drain cnt=0. gnt, done, gb_rd_en, gb_rd_addr and busy all 0.
- States: IDLE -> BURST -> DRAIN -> IDLE.
- IDLE:
  - If req != 0, select the first set bit scanning ptr, ptr+1, ... mod PE_BLOCK.
  - Register owner, addr = req_addr[owner], cnt = req_len[owner].
  - Go to BURST. gnt and gb_rd_en are asserted the next cycle (1-cycle request-to-grant latency).
- BURST:
  - gb_rd_en=1. On each accepted beat: addr++ (wraps mod 2^ADDR_W); if cnt==0 go to DRAIN, else cnt--.
  - gb_rd_rdy low stalls: addr and cnt hold, gb_rd_en stays 1.
- DRAIN:
  - gb_rd_en=0. Count RD_LAT cycles.
  - In the last DRAIN cycle, done[owner]=1 for one cycle. gnt drops in the following cycle.
  - ptr = owner+1 mod PE_BLOCK. Return to IDLE.
- Minimum one IDLE cycle between transactions.
- pe_dat_vld = gb_dat_vld ? gnt : 0. gb_dat_vld while gnt==0 is dropped.
- req[owner] deasserting mid-transaction is ignored; the burst completes and done still pulses.
- req/addr/len of non-owners are sampled only in IDLE; changes during BURST/DRAIN have no effect.
- A requester still asserting req after its done is re-arbitrated at lowest priority (ptr has moved past it).
- A single requester continuously asserting req is re-granted back-to-back with a one-cycle IDLE gap.
- len = 2^LEN_W-1 gives 2^LEN_W beats. Address wrap inside a burst is legal.

Optional Feature:
GB_SCHED_PERF_EN:
- Defined: adds outputs perf_bursts (32b, +1 per done) and perf_stall (32b, +1 per BURST cycle with gb_rd_rdy=0). Both saturate at all-ones and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package gb_pkg: state encoding (IDLE/BURST/DRAIN), default ADDR_W/LEN_W, and a function onehot from index.
- One sub-module, rr_pick: combinational rotating-priority first-one finder (req, ptr -> idx, any).

Test Plan:
- Single req[3]=1, addr=0x010, len=2, rdy=1, RD_LAT=1 -> gnt=0x0008 at cycle 1; addresses 0x010,0x011,0x012 on cycles 1-3; done[3] at cycle 4; busy low at cycle 5.
- req=0xFFFF held, all len=0 -> grant order 0,1,2,...,15,0; each PE granted exactly once per 16 transactions.
- Backpressure: len=3, gb_rd_rdy low on alternate cycles -> exactly 4 beats accepted, addr increments only on accepted cycles, gb_rd_en stays high, no dropped beats.
- Wrap: addr=0xFFE, len=3 -> addresses 0xFFE,0xFFF,0x000,0x001.
- Owner drops req mid-burst while req[7] rises -> burst finishes, done pulses to owner, then PE7 is granted.
- rst_n low during BURST -> all outputs 0 immediately; after release with req=0x0002 -> gnt=0x0002 (ptr back to 0).
